// File: rtl/spi_prog_loader.sv
// Serial program/data loader: takes {data, addr} frames over valid/ready and
// shifts them LSB-first to the processor load port under a per-frame select.
module spi_prog_loader #(
  parameter int unsigned FRAME_W    = 12,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_data_in,
  input  logic               frame_tgt_in,
  input  logic               frame_valid_in,
  output logic               frame_ready_out,
  input  logic               abort_in,
  output logic               csi_out,
  output logic               csd_out,
  output logic               mosi_out,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic [3:0]         frames_sent_out
);

  localparam int unsigned BIT_CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned SENT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [FRAME_W-1:0]   shreg, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_d;
  logic                 tgt, tgt_d;
  logic                 csi_d, csd_d, mosi_d, busy_d, done_d;
  logic [SENT_W-1:0]    sent_d;

  // Ready is decoded straight from state so an offered frame is taken at once.
  assign frame_ready_out = (state == ST_IDLE);

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      gap_cnt         <= '0;
      tgt             <= 1'b0;
      csi_out         <= 1'b0;
      csd_out         <= 1'b0;
      mosi_out        <= 1'b0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      frames_sent_out <= '0;
    end else begin
      state           <= state_d;
      shreg           <= shreg_d;
      bit_cnt         <= bit_cnt_d;
      gap_cnt         <= gap_cnt_d;
      tgt             <= tgt_d;
      csi_out         <= csi_d;
      csd_out         <= csd_d;
      mosi_out        <= mosi_d;
      busy_out        <= busy_d;
      frame_done_out  <= done_d;
      frames_sent_out <= sent_d;
    end
  end

  // Next state; outputs are computed one cycle ahead so selects never glitch.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    tgt_d     = tgt;
    csi_d     = 1'b0;
    csd_d     = 1'b0;
    mosi_d    = 1'b0;
    done_d    = 1'b0;
    sent_d    = frames_sent_out;

    case (state)
      ST_IDLE: begin
        if (frame_valid_in) begin
          state_d   = ST_SHIFT;
          shreg_d   = frame_data_in;
          tgt_d     = frame_tgt_in;
          bit_cnt_d = '0;
          csi_d     = ~frame_tgt_in;
          csd_d     = frame_tgt_in;
          mosi_d    = frame_data_in[0];
        end
      end

      ST_SHIFT: begin
        shreg_d   = shreg >> 1;
        bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
        // Abort wins over completion on the final bit edge.
        if (abort_in) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          done_d    = 1'b1;
          sent_d    = frames_sent_out + SENT_W'(1);
        end else begin
          csi_d  = ~tgt;
          csd_d  = tgt;
          mosi_d = shreg_d[0];
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt + GAP_CNT_W'(1);
        if (gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Scoreboard bench for spi_prog_loader: expected frames are queued when driven
// and matched against what a model of the processor receive register captures.
module tb_spi_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] frame_data_in = '0;
  logic        frame_tgt_in = 1'b0;
  logic        frame_valid_in = 1'b0;
  logic        frame_ready_out;
  logic        abort_in = 1'b0;
  logic        csi_out, csd_out, mosi_out, busy_out, frame_done_out;
  logic [3:0]  frames_sent_out;

  spi_prog_loader #(.FRAME_W(12), .GAP_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_data_in   (frame_data_in),
    .frame_tgt_in    (frame_tgt_in),
    .frame_valid_in  (frame_valid_in),
    .frame_ready_out (frame_ready_out),
    .abort_in        (abort_in),
    .csi_out         (csi_out),
    .csd_out         (csd_out),
    .mosi_out        (mosi_out),
    .busy_out        (busy_out),
    .frame_done_out  (frame_done_out),
    .frames_sent_out (frames_sent_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic        tgt;
    int          len;
    bit          done;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  bit          mon_active = 0;
  int          mon_len = 0;
  logic        mon_tgt = 1'b0;
  logic [11:0] mon_rx = '0;
  logic [11:0] mon_last_rx = '0;
  int          mon_start = 0;
  int          mon_interval = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receive-side model plus per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    logic [11:0] got, mask;
    if (!rst_n) begin
      mon_active = 0;
    end else begin
      checks++;
      if (csi_out && csd_out) begin
        failures++;
        $display("FAIL sel_exclusive: csi=%b csd=%b, required not both high", csi_out, csd_out);
      end
      checks++;
      if (!csi_out && !csd_out && mosi_out !== 1'b0) begin
        failures++;
        $display("FAIL mosi_idle: mosi=%b with selects low, required 0", mosi_out);
      end
      checks++;
      if (busy_out !== !frame_ready_out) begin
        failures++;
        $display("FAIL busy_vs_ready: busy=%b ready=%b, required complementary", busy_out, frame_ready_out);
      end
      if (csi_out || csd_out) begin
        if (!mon_active) begin
          mon_active   = 1;
          mon_len      = 0;
          mon_rx       = '0;
          mon_tgt      = csd_out;
          mon_interval = cyc - mon_start;
          mon_start    = cyc;
        end else begin
          checks++;
          if (csd_out !== mon_tgt) begin
            failures++;
            $display("FAIL sel_switch: csd=%b mid-frame, required %b", csd_out, mon_tgt);
          end
        end
        mon_rx = {mosi_out, mon_rx[11:1]};
        mon_len++;
      end else if (mon_active) begin
        mon_active  = 0;
        mon_last_rx = mon_rx;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame: got %0d bits rx=%h, required no frame", mon_len, mon_rx);
        end else begin
          e = exp_q.pop_front();
          got  = mon_rx >> (12 - mon_len);
          mask = 12'hFFF >> (12 - e.len);
          checks++;
          if (mon_len != e.len) begin
            failures++;
            $display("FAIL frame_len: select high %0d cycles, required %0d", mon_len, e.len);
          end
          checks++;
          if (mon_tgt !== e.tgt) begin
            failures++;
            $display("FAIL frame_tgt: csd=%b, required %b", mon_tgt, e.tgt);
          end
          checks++;
          if (got !== (e.data & mask)) begin
            failures++;
            $display("FAIL frame_bits: got %h, required %h", got, e.data & mask);
          end
          checks++;
          if (frame_done_out !== e.done) begin
            failures++;
            $display("FAIL done_pulse: frame_done=%b after frame, required %b", frame_done_out, e.done);
          end
        end
      end
      if (frame_done_out) done_cnt++;
    end
  end

  task automatic expect_frame(input logic [11:0] d, input logic t, input int len, input bit done);
    exp_t x;
    x.data = d; x.tgt = t; x.len = len; x.done = done;
    exp_q.push_back(x);
  endtask

  // Offers one frame and returns just after its accept edge.
  task automatic send_frame(input logic [11:0] d, input logic t);
    int n = 0;
    while (!frame_ready_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", frame_ready_out, n);
    end
    frame_data_in  = d;
    frame_tgt_in   = t;
    frame_valid_in = 1'b1;
    @(posedge clk); #1;
    frame_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!frame_ready_out || mon_active || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL idle_timeout: ready=%b pending=%0d, required idle with empty queue", frame_ready_out, exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    repeat (3) @(posedge clk);
    #1;
    obs = {csi_out, csd_out, mosi_out, frame_done_out, busy_out, frame_ready_out, frames_sent_out};
    checks++;
    if (obs !== 10'b00000_1_0000) begin
      failures++;
      $display("FAIL reset_state: outputs %b, required 0000010000", obs);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      obs = {csi_out, csd_out, mosi_out, frame_done_out, busy_out, frame_ready_out, frames_sent_out};
      checks++;
      if (obs !== 10'b00000_1_0000) begin
        failures++;
        $display("FAIL idle_hold: cycle %0d outputs %b, required 0000010000", i, obs);
      end
    end
  endtask

  task automatic test_single_instr();
    int d0 = done_cnt;
    expect_frame(12'hA53, 1'b0, 12, 1'b1);
    send_frame(12'hA53, 1'b0);
    wait_idle();
    checks++;
    if (frames_sent_out !== 4'd1) begin
      failures++;
      $display("FAIL single_count: frames_sent=%0d, required 1", frames_sent_out);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL single_done: %0d pulses, required 1", done_cnt - d0);
    end
    checks++;
    if (mon_last_rx !== 12'hA53) begin
      failures++;
      $display("FAIL rx_model: captured %h, required a53", mon_last_rx);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] base = frames_sent_out;
    int d0 = done_cnt;
    int n = 0;
    expect_frame(12'h0FF, 1'b1, 12, 1'b1);
    expect_frame(12'h1E0, 1'b1, 12, 1'b1);
    frame_data_in  = 12'h0FF;
    frame_tgt_in   = 1'b1;
    frame_valid_in = 1'b1;
    @(posedge clk); #1;
    frame_data_in = 12'h1E0;
    @(posedge clk); #1;
    while (!frame_ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    frame_valid_in = 1'b0;
    wait_idle();
    checks++;
    if (mon_interval != 15) begin
      failures++;
      $display("FAIL b2b_interval: %0d cycles between frame starts, required 15", mon_interval);
    end
    checks++;
    if (frames_sent_out !== 4'(base + 4'd2)) begin
      failures++;
      $display("FAIL b2b_count: frames_sent=%0d, required %0d", frames_sent_out, 4'(base + 4'd2));
    end
    checks++;
    if (done_cnt - d0 != 2) begin
      failures++;
      $display("FAIL b2b_done: %0d pulses, required 2", done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    logic [3:0] base = frames_sent_out;
    int d0 = done_cnt;
    // Abort while bit 5 is on the wire: bits 0..5 go out, then selects drop.
    expect_frame(12'h555, 1'b0, 6, 1'b0);
    send_frame(12'h555, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    abort_in = 1'b1;
    @(posedge clk); #1;
    abort_in = 1'b0;
    checks++;
    if (csi_out !== 1'b0 || frame_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop: csi=%b ready=%b, required 0 0", csi_out, frame_ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_gap: ready=%b in 2nd gap cycle, required 0", frame_ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready: ready=%b after gap, required 1", frame_ready_out);
    end
    // Abort on the final bit edge beats completion.
    expect_frame(12'h9C3, 1'b1, 12, 1'b0);
    send_frame(12'h9C3, 1'b1);
    repeat (11) begin @(posedge clk); #1; end
    abort_in = 1'b1;
    @(posedge clk); #1;
    abort_in = 1'b0;
    wait_idle();
    checks++;
    if (frames_sent_out !== base || done_cnt != d0) begin
      failures++;
      $display("FAIL abort_count: frames_sent=%0d done=%0d, required %0d 0", frames_sent_out, done_cnt - d0, base);
    end
    // Abort held in IDLE does not disturb the accept.
    abort_in = 1'b1;
    expect_frame(12'h5A6, 1'b0, 12, 1'b1);
    send_frame(12'h5A6, 1'b0);
    abort_in = 1'b0;
    wait_idle();
    checks++;
    if (frames_sent_out !== 4'(base + 4'd1)) begin
      failures++;
      $display("FAIL abort_idle: frames_sent=%0d, required %0d", frames_sent_out, 4'(base + 4'd1));
    end
  endtask

  task automatic test_input_stability();
    expect_frame(12'h3C6, 1'b1, 12, 1'b1);
    send_frame(12'h3C6, 1'b1);
    repeat (12) begin
      frame_data_in = 12'($urandom);
      frame_tgt_in  = 1'($urandom);
      @(posedge clk); #1;
    end
    frame_data_in = '0;
    frame_tgt_in  = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_shift();
    logic [9:0] obs;
    expect_frame(12'h7E1, 1'b1, 12, 1'b1);
    send_frame(12'h7E1, 1'b1);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    obs = {csi_out, csd_out, mosi_out, frame_done_out, busy_out, frame_ready_out, frames_sent_out};
    checks++;
    if (obs !== 10'b00000_1_0000) begin
      failures++;
      $display("FAIL reset_mid_shift: outputs %b, required 0000010000", obs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (frame_ready_out !== 1'b1 || csd_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b csd=%b, required 1 0", frame_ready_out, csd_out);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] d;
    for (int i = 0; i < 17; i++) begin
      d = 12'($urandom);
      expect_frame(d, i[0], 12, 1'b1);
      send_frame(d, i[0]);
      wait_idle();
      checks++;
      if (frames_sent_out !== 4'(i + 1)) begin
        failures++;
        $display("FAIL wrap_count: after frame %0d frames_sent=%0d, required %0d", i + 1, frames_sent_out, 4'(i + 1));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_instr();
    test_back_to_back();
    test_abort();
    test_input_stability();
    test_reset_mid_shift();
    test_wrap();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
